// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : arb_pkg
// Purpose : Shared FSM state encoding and arbitration-mode constants.
// Rev     : 1.0
// ============================================================================
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam int ARB_DPRI = 0;
  localparam int ARB_RR   = 1;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Purpose : Arbitrates instruction fetch and data load/store onto one RAM port.
// Rev     : 1.0
// ============================================================================
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int RAM_LAT  = 2,
  parameter int ARB_MODE = 0
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_ren,
  output logic              ram_wen,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_busy
);

  localparam int              CNT_W    = $clog2(RAM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAM_LAT - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  // Side of the current/most recent grant: 1 = data, 0 = instruction.
  logic                last_d_q, last_d_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic                w_d_req;
  logic                w_grant_d;

  assign w_d_req   = d_ren | d_wen;
  assign w_grant_d = w_d_req &
                     (!i_req || (ARB_MODE == ARB_DPRI) || !last_d_q);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_d_q  <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_d_q  <= last_d_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d_d  = last_d_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (i_req || w_d_req) begin
          cnt_d    = '0;
          last_d_d = w_grant_d;
          if (w_grant_d) begin
            state_d = D_WAIT;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            wr_d    = d_wen;
          end else begin
            state_d = I_WAIT;
            addr_d  = i_addr;
            wr_d    = 1'b0;
          end
        end
      end
      I_WAIT, D_WAIT: begin
        // A stalled RAM freezes everything, including the counter.
        if (!ram_busy) begin
          if (cnt_q == CNT_LAST) begin
            state_d = RESP;
            if (state_q == I_WAIT) begin
              i_rdata_d = ram_rdata;
            end else if (!wr_q) begin
              d_rdata_d = ram_rdata;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ram_ren   = (state_q == I_WAIT) || ((state_q == D_WAIT) && !wr_q);
  assign ram_wen   = (state_q == D_WAIT) && wr_q;
  assign i_ready   = (state_q == RESP) && !last_d_q;
  assign d_ready   = (state_q == RESP) && last_d_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Purpose : Directed scoreboard bench for mem_arbiter (data-priority + RR).
// Rev     : 1.0
// ============================================================================
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        nRST;
  logic        i_req, d_ren, d_wen, ram_busy;
  logic [31:0] i_addr, d_addr, d_wdata;

  logic        i_ready, d_ready, ram_ren, ram_wen;
  logic [31:0] i_rdata, d_rdata, ram_addr, ram_wdata, ram_rdata;

  logic        rr_i_ready, rr_d_ready, rr_ram_ren, rr_ram_wen;
  logic [31:0] rr_i_rdata, rr_d_rdata, rr_ram_addr, rr_ram_wdata, rr_ram_rdata;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ram_model(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return a ^ 32'h5A5A_C3C3;
  endfunction

  assign ram_rdata    = ram_model(ram_addr);
  assign rr_ram_rdata = ram_model(rr_ram_addr);

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(2), .ARB_MODE(0)) u_dut (
    .clk(clk), .nRST(nRST),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_ren(ram_ren),
    .ram_wen(ram_wen), .ram_rdata(ram_rdata), .ram_busy(ram_busy)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(2), .ARB_MODE(1)) u_dut_rr (
    .clk(clk), .nRST(nRST),
    .i_req(i_req), .i_addr(i_addr), .i_ready(rr_i_ready), .i_rdata(rr_i_rdata),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(rr_d_ready), .d_rdata(rr_d_rdata),
    .ram_addr(rr_ram_addr), .ram_wdata(rr_ram_wdata), .ram_ren(rr_ram_ren),
    .ram_wen(rr_ram_wen), .ram_rdata(rr_ram_rdata), .ram_busy(ram_busy)
  );

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_d = 32'h0;
  int          c0;
  int          pulses;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit is_d, input logic [31:0] data, input int c);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    e.cyc  = c;
    sb_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge where a ready pulse is seen.
  task automatic wait_resp(input string tag);
    exp_t e;
    int   n;
    n = 0;
    e = sb_q.pop_front();
    do begin
      @(negedge clk);
      n++;
    end while (!(i_ready || d_ready) && n < 40);
    chk({tag, "_seen"}, {63'd0, i_ready | d_ready}, 64'd1);
    if (i_ready || d_ready) begin
      chk({tag, "_d_ready"}, {63'd0, d_ready}, {63'd0, e.is_d});
      chk({tag, "_i_ready"}, {63'd0, i_ready}, {63'd0, !e.is_d});
      chk({tag, "_cycle"}, 64'(cyc), 64'(e.cyc));
      chk({tag, "_rdata"}, {32'd0, (e.is_d ? d_rdata : i_rdata)}, {32'd0, e.data});
    end
  endtask

  initial begin
    nRST = 1'b0; i_req = 1'b0; d_ren = 1'b0; d_wen = 1'b0; ram_busy = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ram_ren", {63'd0, ram_ren}, 64'd0);
    chk("rst_ram_wen", {63'd0, ram_wen}, 64'd0);
    chk("rst_ready", {62'd0, i_ready, d_ready}, 64'd0);
    chk("rst_ram_addr", {32'd0, ram_addr}, 64'd0);
    chk("rst_rdata", {i_rdata, d_rdata}, 64'd0);
    nRST = 1'b1;
    @(negedge clk);

    // Single instruction fetch.
    i_req = 1'b1; i_addr = 32'h100; c0 = cyc;
    push(1'b0, 32'hDEAD_BEEF, c0 + 3);
    @(negedge clk);
    chk("t1_ren_a", {63'd0, ram_ren}, 64'd1);
    chk("t1_wen", {63'd0, ram_wen}, 64'd0);
    chk("t1_addr", {32'd0, ram_addr}, 64'h100);
    @(negedge clk);
    chk("t1_ren_b", {63'd0, ram_ren}, 64'd1);
    wait_resp("t1");
    chk("t1_ren_resp", {63'd0, ram_ren}, 64'd0);
    i_req = 1'b0;
    @(negedge clk);

    // Contention in data-priority mode: data first, then the held fetch.
    i_req = 1'b1; i_addr = 32'h300; d_ren = 1'b1; d_addr = 32'h400; c0 = cyc;
    push(1'b1, ram_model(32'h400), c0 + 3);
    push(1'b0, ram_model(32'h300), c0 + 7);
    exp_d = ram_model(32'h400);
    @(negedge clk);
    chk("cont_addr", {32'd0, ram_addr}, 64'h400);
    wait_resp("cont_d");
    d_ren = 1'b0;
    wait_resp("cont_i");
    i_req = 1'b0;
    @(negedge clk);

    // Plain write: strobe, address, data; load data untouched.
    d_wen = 1'b1; d_addr = 32'h2000; d_wdata = 32'h1234_5678; c0 = cyc;
    push(1'b1, exp_d, c0 + 3);
    @(negedge clk);
    chk("wr_wen", {63'd0, ram_wen}, 64'd1);
    chk("wr_ren", {63'd0, ram_ren}, 64'd0);
    chk("wr_addr", {32'd0, ram_addr}, 64'h2000);
    chk("wr_wdata", {32'd0, ram_wdata}, 64'h1234_5678);
    wait_resp("wr");
    d_wen = 1'b0;
    @(negedge clk);
    chk("idle_addr_hold", {32'd0, ram_addr}, 64'h2000);

    // Read and write together: write wins.
    d_ren = 1'b1; d_wen = 1'b1; d_addr = 32'h2400; d_wdata = 32'hCAFE_F00D; c0 = cyc;
    push(1'b1, exp_d, c0 + 3);
    @(negedge clk);
    chk("rw_wen", {63'd0, ram_wen}, 64'd1);
    chk("rw_ren", {63'd0, ram_ren}, 64'd0);
    chk("rw_wdata", {32'd0, ram_wdata}, 64'hCAFE_F00D);
    wait_resp("rw");
    d_ren = 1'b0; d_wen = 1'b0;
    @(negedge clk);

    // Read stalled by ram_busy for 3 cycles; request changes are ignored.
    d_ren = 1'b1; d_addr = 32'h500; c0 = cyc;
    push(1'b1, ram_model(32'h500), c0 + 6);
    exp_d = ram_model(32'h500);
    @(negedge clk);
    ram_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("busy_ren", {63'd0, ram_ren}, 64'd1);
      if (k == 1) d_addr = 32'h900;
      @(negedge clk);
    end
    ram_busy = 1'b0;
    chk("busy_ren_end", {63'd0, ram_ren}, 64'd1);
    chk("busy_addr_latched", {32'd0, ram_addr}, 64'h500);
    wait_resp("busy");
    d_ren = 1'b0;
    @(negedge clk);

    // Both sides after a data grant: RR instance serves the fetch first.
    i_req = 1'b1; i_addr = 32'h600; d_ren = 1'b1; d_addr = 32'h700; c0 = cyc;
    push(1'b1, ram_model(32'h700), c0 + 3);
    exp_d = ram_model(32'h700);
    @(negedge clk);
    chk("rr_dpri_addr", {32'd0, ram_addr}, 64'h700);
    chk("rr_addr", {32'd0, rr_ram_addr}, 64'h600);
    chk("rr_ren", {63'd0, rr_ram_ren}, 64'd1);
    wait_resp("rr_main");
    chk("rr_i_ready", {63'd0, rr_i_ready}, 64'd1);
    chk("rr_d_ready", {63'd0, rr_d_ready}, 64'd0);
    chk("rr_i_rdata", {32'd0, rr_i_rdata}, {32'd0, ram_model(32'h600)});
    i_req = 1'b0; d_ren = 1'b0;
    @(negedge clk);

    // Reset during I_WAIT discards the access.
    i_req = 1'b1; i_addr = 32'h800;
    @(negedge clk);
    chk("rst_mid_ren_pre", {63'd0, ram_ren}, 64'd1);
    nRST = 1'b0;
    #1;
    chk("rst_mid_ren", {63'd0, ram_ren}, 64'd0);
    chk("rst_mid_addr", {32'd0, ram_addr}, 64'd0);
    chk("rst_mid_rdata", {i_rdata, d_rdata}, 64'd0);
    chk("rst_mid_ready", {62'd0, i_ready, d_ready}, 64'd0);
    exp_d = 32'h0;
    i_req = 1'b0;
    @(negedge clk);
    nRST = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      pulses += int'(i_ready | d_ready);
    end
    chk("rst_no_ready", 64'(pulses), 64'd0);

    i_req = 1'b1; i_addr = 32'h100; c0 = cyc;
    push(1'b0, 32'hDEAD_BEEF, c0 + 3);
    wait_resp("post_rst");
    i_req = 1'b0;
    @(negedge clk);
    chk("post_rst_d_rdata", {32'd0, d_rdata}, {32'd0, exp_d});
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
